// File: rtl/nmr_qsw_window_seq.sv
// Multi-echo Q-switch enable sequencer: delayed EN_QSW per acquisition window, echo counting, DONE pulse.
// Optional ACTIVE-state watchdog is built when QSW_TIMEOUT_EN is defined.
module nmr_qsw_window_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int DLY_W       = 8,
  parameter int CNT_W       = 16,
  parameter int TMO_CYC     = 65535
) (
  input  logic             ADC_CLK,
  input  logic             RESET,
  input  logic             ACQ_WND,
  input  logic             ACQ_WND_PULSED,
  input  logic             ARM,
  input  logic [DLY_W-1:0] START_DLY,
  input  logic [DLY_W-1:0] STOP_EXT,
  input  logic [CNT_W-1:0] ECHO_NUM,
  output logic             EN_QSW,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ECHO_CNT,
  output logic             TMO_ERR
);

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_WAIT_LOW  = 6'b000010,
    S_WAIT_RISE = 6'b000100,
    S_DELAY     = 6'b001000,
    S_ACTIVE    = 6'b010000,
    S_EXTEND    = 6'b100000
  } state_e;

  state_e state_q;

  logic [SYNC_STAGES-1:0] acq_sync_q;
  logic [SYNC_STAGES-1:0] pls_sync_q;
  logic                   pls_d_q;
  logic                   acq_s;
  logic                   pls_s;
  logic                   pls_rise;

  logic                   en_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CNT_W-1:0]       echo_cnt_q;
  logic [CNT_W-1:0]       echo_cnt_d;
  logic [DLY_W-1:0]       dly_cnt_q;
  logic [DLY_W-1:0]       start_dly_q;
  logic [DLY_W-1:0]       stop_ext_q;
  logic [CNT_W-1:0]       echo_num_q;

  logic                   echo_fin;
  logic                   seq_last;
  logic                   tmo_hit;

  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      acq_sync_q <= '0;
      pls_sync_q <= '0;
      pls_d_q    <= 1'b0;
    end else begin
      acq_sync_q[0] <= ACQ_WND;
      pls_sync_q[0] <= ACQ_WND_PULSED;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        acq_sync_q[i] <= acq_sync_q[i-1];
        pls_sync_q[i] <= pls_sync_q[i-1];
      end
      pls_d_q <= pls_s;
    end
  end

  assign acq_s    = acq_sync_q[SYNC_STAGES-1];
  assign pls_s    = pls_sync_q[SYNC_STAGES-1];
  assign pls_rise = pls_s & ~pls_d_q;

`ifdef QSW_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;

  // Restarts from zero on every entry into ACTIVE.
  always_ff @(posedge ADC_CLK) begin
    if (RESET || (state_q != S_ACTIVE)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_hit = (state_q == S_ACTIVE) && !pls_rise && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
  assign TMO_ERR = tmo_err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_hit    = 1'b0;
  assign TMO_ERR    = 1'b0;
`endif

  // An echo ends on the edge EN_QSW falls, or on a PULSED rise that arrives before EN_QSW ever rose.
  always_comb begin
    echo_fin = 1'b0;
    case (state_q)
      S_DELAY:  echo_fin = pls_rise;
      S_ACTIVE: echo_fin = pls_rise && (stop_ext_q == '0);
      S_EXTEND: echo_fin = (dly_cnt_q == DLY_W'(1));
      default:  echo_fin = 1'b0;
    endcase
  end

  assign echo_cnt_d = echo_cnt_q + CNT_W'(1);
  assign seq_last   = (echo_num_q != '0) && (echo_cnt_d == echo_num_q);

  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      echo_cnt_q  <= '0;
      dly_cnt_q   <= '0;
      start_dly_q <= '0;
      stop_ext_q  <= '0;
      echo_num_q  <= '0;
`ifdef QSW_TIMEOUT_EN
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if ((state_q != S_IDLE) && !ARM) begin
        state_q <= S_IDLE;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (echo_fin) begin
        en_q       <= 1'b0;
        echo_cnt_q <= echo_cnt_d;
        if (seq_last) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end else begin
          state_q <= S_WAIT_LOW;
        end
      end else if (tmo_hit) begin
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
        state_q <= S_IDLE;
`ifdef QSW_TIMEOUT_EN
        tmo_err_q <= 1'b1;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ARM) begin
              echo_cnt_q  <= '0;
              start_dly_q <= START_DLY;
              stop_ext_q  <= STOP_EXT;
              echo_num_q  <= ECHO_NUM;
              busy_q      <= 1'b1;
              state_q     <= S_WAIT_LOW;
`ifdef QSW_TIMEOUT_EN
              tmo_err_q   <= 1'b0;
`endif
            end
          end
          S_WAIT_LOW: begin
            if (!acq_s) state_q <= S_WAIT_RISE;
          end
          S_WAIT_RISE: begin
            if (acq_s) begin
              if (start_dly_q == '0) begin
                en_q    <= 1'b1;
                state_q <= S_ACTIVE;
              end else begin
                dly_cnt_q <= start_dly_q;
                state_q   <= S_DELAY;
              end
            end
          end
          S_DELAY: begin
            if (dly_cnt_q == DLY_W'(1)) begin
              en_q    <= 1'b1;
              state_q <= S_ACTIVE;
            end else begin
              dly_cnt_q <= dly_cnt_q - DLY_W'(1);
            end
          end
          S_ACTIVE: begin
            if (pls_rise) begin
              dly_cnt_q <= stop_ext_q;
              state_q   <= S_EXTEND;
            end
          end
          S_EXTEND: begin
            dly_cnt_q <= dly_cnt_q - DLY_W'(1);
          end
          default: begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign EN_QSW   = en_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ECHO_CNT = echo_cnt_q;

endmodule
